alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one parameterized registered ALU between two requesters.
- Each requester issues {func, A, B} over a valid/ready handshake. The block picks one requester round-robin, drives the ALU from registered operands, and waits the ALU's pipeline latency.
- It returns the result, carry and compare flags on one tagged response channel with valid/ready back-pressure.
- It sits between the ALU and its client blocks, and is the only driver of the ALU's function and operand inputs.

Parameters:
- N, 16, operand/result width; must match the ALU's N.
- ALU_LAT, 1, number of clock edges from stable ALU inputs to valid ALU_out/flags; 0 means a combinational ALU; legal range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_func  in  4  ALU function code (same encoding as ALU_Func).
- req0_a, req0_b  in  N  operands A and B.
- req1_valid, req1_ready, req1_func, req1_a, req1_b  same as requester 0, for requester 1.
- alu_func  out  4  to ALU ALU_Func.
- alu_a, alu_b  out  N  to ALU A and B.
- alu_out  in  N  from ALU ALU_out.
- alu_carry  in  1  from ALU Carry.
- alu_cmp  in  1  from ALU CMP.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the response.
- rsp_data  out  N  captured ALU result.
- rsp_carry, rsp_cmp  out  1  captured flags.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  16  count of completed response handshakes; wraps 0xFFFF→0x0000.

Behaviour:
- Reset (asynchronous, rst_n=0), all registers cleared:
  - state=IDLE, rr_ptr=0, ops_done=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, rsp_cmp=0.
  - alu_func=0, alu_a=0, alu_b=0, busy=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, grant selection:
  - Only one valid: grant it.
  - Both valid: grant the requester indexed by rr_ptr.
  - reqX_ready = (state==IDLE) & grantX. It is combinational from the valids, and at most one ready is high.
- IDLE, on the acceptance edge E0:
  - Latch func/A/B into the alu_* registers and latch rsp_id=granted.
  - Set rr_ptr = ~granted.
  - Load wait counter with ALU_LAT and go to WAIT.
  - With no valid, stay in IDLE; the alu_* registers hold their values.
- WAIT:
  - cnt≠0: decrement.
  - cnt==0: capture alu_out/alu_carry/alu_cmp into the rsp_* registers and go to RESP.
  - Capture edge is E0+ALU_LAT+1.
  - rsp_valid is first high in the cycle after the capture edge, i.e. ALU_LAT+2 cycles after req_valid&ready.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_ready=1.
  - On the handshake edge: ops_done+1, go to IDLE.
  - No new request is accepted in RESP. Back-to-back throughput is one op per ALU_LAT+3 cycles.
- alu_* stay stable from E0 until the next acceptance, so the ALU sees constant inputs for the whole WAIT period.
- Function codes are forwarded unmodified, including unused codes 1110/1111 and divide-by-zero. The result is whatever the ALU produces; the arbiter never inspects func.
- Requests not granted must stay asserted; the requester may not change func/A/B while valid and not ready.
- Reset mid-WAIT or mid-RESP: the transaction is dropped with no response, and rr_ptr returns to 0.
- rsp_ready high while rsp_valid is low is ignored.

Test Plan:
- Single op, ALU_LAT=1: req0 ADD A=0x0010 B=0x000A, rsp_ready=1 → req0_ready pulses 1 cycle; rsp_valid rises 3 cycles later with rsp_data=0x001A, rsp_id=0, rsp_carry=0; ops_done=1.
- Carry: req1 ADD A=0xFFFD B=0x0003 → rsp_data=0x0000, rsp_carry=1, rsp_id=1.
- Arbitration: both valid from reset, req0 SUB 16,10 and req1 MUL 16,10 held continuously →
  - Grants go 0,1,0,1.
  - Responses are 6 (id 0), 160 (id 1), 6, 160.
  - A requester never gets two consecutive grants while the other waits.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP (req0 CMP-equal A=B=12886) →
  - rsp_valid and rsp_cmp=1 are held stable.
  - req1_valid=1 gets no ready and busy=1.
  - After rsp_ready=1, the response completes and req1 is accepted on the next cycle.
- Reset mid-operation: assert rst_n=0 during WAIT → immediately rsp_valid=0, busy=0, ops_done=0. After release, both valid → req0 granted first.
- Latency parameter: ALU_LAT=0 with req0 XOR 0x0011,0x1111 → rsp_data=0x1100, rsp_valid 2 cycles after acceptance.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters.
// Requests are granted round-robin. The ALU operands are held in registers
// for the whole ALU latency, and the result comes back on a tagged response
// channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// reqX_ready is combinational from the valids and is only high in IDLE.
// rsp_valid is registered and stays high, with rsp_* held, until rsp_ready.
module alu_arbiter #(
   parameter int N       = 16,
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_func,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_func,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic [3:0]   alu_func,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_out,
   input  logic         alu_carry,
   input  logic         alu_cmp,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_data,
   output logic         rsp_carry,
   output logic         rsp_cmp,
   output logic         busy,
   output logic [15:0]  ops_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // The wait counter is 3 bits wide, so ALU_LAT can be at most 7.
   localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

   state_t     state;
   logic       rr_ptr;
   logic [2:0] cnt;
   logic       grant_id;
   logic       accept;

   // Grant selection: a lone valid wins; when both are valid, rr_ptr decides.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = rr_ptr;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign accept     = (state == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant_id;
   assign req1_ready = accept && grant_id;

   // Control FSM: accept, wait for the ALU latency, capture, then hold the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         cnt       <= 3'd0;
         alu_func  <= 4'd0;
         alu_a     <= '0;
         alu_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_cmp   <= 1'b0;
         busy      <= 1'b0;
         ops_done  <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               // The alu_* registers keep their old values until the next accept.
               if (accept) begin
                  alu_func <= grant_id ? req1_func : req0_func;
                  alu_a    <= grant_id ? req1_a    : req0_a;
                  alu_b    <= grant_id ? req1_b    : req0_b;
                  rsp_id   <= grant_id;
                  rr_ptr   <= ~grant_id;
                  cnt      <= LAT_INIT;
                  busy     <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // When cnt reaches zero, the ALU output reflects the operands latched at accept.
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  rsp_data  <= alu_out;
                  rsp_carry <= alu_carry;
                  rsp_cmp   <= alu_cmp;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ops_done  <= ops_done + 16'd1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed-vector bench for alu_arbiter.
// u0 uses ALU_LAT=1 and u1 uses ALU_LAT=0.
// Each instance is connected to a small behavioural ALU model.
module tb_alu_arbiter;

   localparam int N = 16;
   localparam logic [3:0] F_ADD    = 4'h0;
   localparam logic [3:0] F_SUB    = 4'h1;
   localparam logic [3:0] F_MUL    = 4'h2;
   localparam logic [3:0] F_XOR    = 4'hA;
   localparam logic [3:0] F_CMP    = 4'hD;
   localparam logic [3:0] F_UNUSED = 4'hE;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- u0 (ALU_LAT=1) signals ----------------
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_func = 4'd0, req1_func = 4'd0;
   logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]   alu_func;
   logic [N-1:0] alu_a, alu_b, alu_out;
   logic         alu_carry, alu_cmp;
   logic         rsp_valid, rsp_id, rsp_carry, rsp_cmp, busy;
   logic         rsp_ready = 1'b0;
   logic [N-1:0] rsp_data;
   logic [15:0]  ops_done;

   // ---------------- u1 (ALU_LAT=0) signals ----------------
   logic         l0_req0_valid = 1'b0, l0_req1_valid = 1'b0;
   logic         l0_req0_ready, l0_req1_ready;
   logic [3:0]   l0_req0_func = 4'd0, l0_req1_func = 4'd0;
   logic [N-1:0] l0_req0_a = '0, l0_req0_b = '0, l0_req1_a = '0, l0_req1_b = '0;
   logic [3:0]   l0_alu_func;
   logic [N-1:0] l0_alu_a, l0_alu_b, l0_alu_out;
   logic         l0_alu_carry, l0_alu_cmp;
   logic         l0_rsp_valid, l0_rsp_id, l0_rsp_carry, l0_rsp_cmp, l0_busy;
   logic         l0_rsp_ready = 1'b0;
   logic [N-1:0] l0_rsp_data;
   logic [15:0]  l0_ops_done;

   // ---------------- ALU model: returns {cmp, carry, data} ----------------
   function automatic logic [N+1:0] alu_model(input logic [3:0] f, input logic [N-1:0] a,
                                              input logic [N-1:0] b);
      logic [N:0]     s;
      logic [2*N-1:0] p;
      logic [N-1:0]   d;
      alu_model = '0;
      case (f)
         F_ADD: begin s = {1'b0, a} + {1'b0, b}; alu_model = {1'b0, s}; end
         F_SUB: begin s = {1'b0, a} - {1'b0, b}; alu_model = {1'b0, s}; end
         F_MUL: begin p = a * b; alu_model = {2'b00, p[N-1:0]}; end
         F_XOR: begin d = a ^ b; alu_model = {2'b00, d}; end
         F_CMP: begin d = a - b; alu_model = {(a == b), 1'b0, d}; end
         default: alu_model = '0;
      endcase
   endfunction

   // One-stage registered ALU for u0.
   logic [N+1:0] alu0_q = '0;
   always @(posedge clk) alu0_q <= alu_model(alu_func, alu_a, alu_b);
   assign {alu_cmp, alu_carry, alu_out} = alu0_q;

   // Combinational ALU for u1.
   assign {l0_alu_cmp, l0_alu_carry, l0_alu_out} = alu_model(l0_alu_func, l0_alu_a, l0_alu_b);

   alu_arbiter #(.N(N), .ALU_LAT(1)) u0 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_cmp(alu_cmp),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_cmp(rsp_cmp),
      .busy(busy), .ops_done(ops_done)
   );

   alu_arbiter #(.N(N), .ALU_LAT(0)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(l0_req0_valid), .req0_ready(l0_req0_ready), .req0_func(l0_req0_func),
      .req0_a(l0_req0_a), .req0_b(l0_req0_b),
      .req1_valid(l0_req1_valid), .req1_ready(l0_req1_ready), .req1_func(l0_req1_func),
      .req1_a(l0_req1_a), .req1_b(l0_req1_b),
      .alu_func(l0_alu_func), .alu_a(l0_alu_a), .alu_b(l0_alu_b),
      .alu_out(l0_alu_out), .alu_carry(l0_alu_carry), .alu_cmp(l0_alu_cmp),
      .rsp_valid(l0_rsp_valid), .rsp_ready(l0_rsp_ready), .rsp_id(l0_rsp_id),
      .rsp_data(l0_rsp_data), .rsp_carry(l0_rsp_carry), .rsp_cmp(l0_rsp_cmp),
      .busy(l0_busy), .ops_done(l0_ops_done)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_ops = 16'd0;
   logic [N:0]  exp_q[$];
   logic        exp_grant_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input bit sel, input logic [3:0] f, input logic [N-1:0] a,
                          input logic [N-1:0] b);
      if (sel) begin
         req1_valid = 1'b1; req1_func = f; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_func = f; req0_a = a; req0_b = b;
      end
   endtask

   // Wait (bounded) at negedges until u0 rsp_valid; returns the number of negedges waited.
   task automatic wait_rsp(output int waited);
      waited = 0;
      while (!rsp_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Single op on u0 with rsp_ready=1; checks ready pulse, latency, response and count.
   task automatic run_op(input string tag, input bit sel, input logic [3:0] f,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_data, input bit exp_carry, input bit exp_cmp);
      int w;
      @(negedge clk);
      rsp_ready = 1'b1;
      set_req(sel, f, a, b);
      #1;
      check({tag, " ready"}, {req1_ready, req0_ready}, sel ? 2'b10 : 2'b01);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check({tag, " ready_pulse"}, {req1_ready, req0_ready}, 2'b00);
      wait_rsp(w);
      check({tag, " latency"}, w + 1, 3);
      check({tag, " rsp"}, {rsp_valid, rsp_id, rsp_carry, rsp_cmp, rsp_data},
            {1'b1, sel, exp_carry, exp_cmp, exp_data});
      @(negedge clk);
      exp_ops = exp_ops + 16'd1;
      check({tag, " done"}, {busy, rsp_valid, ops_done}, {2'b00, exp_ops});
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int w;
      int cyc;
      int nresp;
      logic [N:0] e;

      // Reset values
      repeat (2) @(negedge clk);
      check("reset rsp", {rsp_valid, rsp_id, rsp_carry, rsp_cmp, rsp_data}, 0);
      check("reset alu", {alu_func, alu_a, alu_b}, 0);
      check("reset busy_ops", {busy, ops_done}, 0);
      rst_n = 1'b1;

      // Single op and carry-out
      run_op("add", 1'b0, F_ADD, 16'h0010, 16'h000A, 16'h001A, 1'b0, 1'b0);
      check("alu_hold", {alu_func, alu_a, alu_b}, {F_ADD, 16'h0010, 16'h000A});
      run_op("carry", 1'b1, F_ADD, 16'hFFFD, 16'h0003, 16'h0000, 1'b1, 1'b0);

      // Unused function code is forwarded unmodified
      run_op("unused", 1'b0, F_UNUSED, 16'h0005, 16'h0007, 16'h0000, 1'b0, 1'b0);
      check("unused func fwd", alu_func, F_UNUSED);

      // rsp_ready while idle must not count anything
      repeat (3) @(negedge clk);
      check("idle rsp_ready", {rsp_valid, ops_done}, {1'b0, exp_ops});

      // Arbitration from reset: both requesters held valid
      @(negedge clk);
      rst_n = 1'b0;
      set_req(1'b0, F_SUB, 16'd16, 16'd10);
      set_req(1'b1, F_MUL, 16'd16, 16'd10);
      rsp_ready = 1'b1;
      exp_ops = 16'd0;
      exp_grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_q = '{{1'b0, 16'd6}, {1'b1, 16'd160}, {1'b0, 16'd6}, {1'b1, 16'd160}};
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      nresp = 0;
      cyc = 0;
      while (nresp < 4 && cyc < 100) begin
         if (req0_ready || req1_ready) begin
            check("arb one_hot", {req1_ready, req0_ready} == 2'b11, 0);
            if (exp_grant_q.size() == 0) check("arb extra_grant", 1, 0);
            else check("arb grant", req1_ready, exp_grant_q.pop_front());
         end
         if (rsp_valid) begin
            e = exp_q.pop_front();
            check("arb rsp", {rsp_id, rsp_data}, e);
            nresp++;
            if (nresp == 4) begin
               req0_valid = 1'b0;
               req1_valid = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      exp_ops = 16'd4;
      check("arb count", nresp, 4);
      check("arb grants_left", exp_grant_q.size(), 0);
      check("arb ops_done", ops_done, exp_ops);

      // Back-pressure: response held for 5 cycles, req1 waits
      rsp_ready = 1'b0;
      set_req(1'b0, F_CMP, 16'd12886, 16'd12886);
      #1;
      check("bp ready0", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      set_req(1'b1, F_ADD, 16'd1, 16'd2);
      wait_rsp(w);
      for (int i = 0; i < 5; i++) begin
         check("bp hold", {rsp_valid, rsp_id, rsp_cmp, rsp_data}, {1'b1, 1'b0, 1'b1, 16'd0});
         check("bp stall", {busy, req1_ready}, 2'b10);
         @(negedge clk);
      end
      check("bp hold_last", {rsp_valid, rsp_cmp}, 2'b11);
      rsp_ready = 1'b1;
      @(negedge clk);
      exp_ops = exp_ops + 16'd1;
      check("bp done", {rsp_valid, ops_done}, {1'b0, exp_ops});
      check("bp req1 accept", req1_ready, 1);
      @(negedge clk);
      req1_valid = 1'b0;
      check("bp busy", busy, 1);
      wait_rsp(w);
      check("bp rsp1", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'd3});
      @(negedge clk);
      exp_ops = exp_ops + 16'd1;
      check("bp ops", ops_done, exp_ops);

      // Reset during WAIT drops the transaction and returns rr_ptr to 0
      set_req(1'b0, F_ADD, 16'd1, 16'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      check("rst pre busy", busy, 1);
      rst_n = 1'b0;
      #1;
      exp_ops = 16'd0;
      check("rst drop", {rsp_valid, busy, ops_done}, {2'b00, exp_ops});
      set_req(1'b0, F_ADD, 16'd2, 16'd3);
      set_req(1'b1, F_ADD, 16'd4, 16'd4);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst grant0", {req1_ready, req0_ready}, 2'b01);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(w);
      check("rst rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 16'd5});
      @(negedge clk);
      exp_ops = exp_ops + 16'd1;
      check("rst ops", ops_done, exp_ops);

      // ALU_LAT=0 instance: response two cycles after acceptance
      l0_rsp_ready = 1'b1;
      l0_req0_valid = 1'b1;
      l0_req0_func = F_XOR;
      l0_req0_a = 16'h0011;
      l0_req0_b = 16'h1111;
      #1;
      check("lat0 ready", l0_req0_ready, 1);
      @(negedge clk);
      l0_req0_valid = 1'b0;
      w = 1;
      while (!l0_rsp_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("lat0 latency", w, 2);
      check("lat0 rsp", {l0_rsp_valid, l0_rsp_id, l0_rsp_data}, {1'b1, 1'b0, 16'h1100});
      @(negedge clk);
      check("lat0 ops", {l0_rsp_valid, l0_ops_done}, {1'b0, 16'd1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
